// File: rtl/six_step_sequencer.sv
// Six-step trapezoidal commutation scheduler: walks a one-hot gate vector through the
// six active voltage vectors with a programmable dwell and optional zero-vector gap.
module six_step_sequencer #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 dir,
    input  logic [CNT_WIDTH-1:0] dwell,
    input  logic [CNT_WIDTH-1:0] blank,
    output logic [5:0]           gates,
    output logic [2:0]           step,
    output logic                 step_strobe,
    output logic                 rev_done,
    output logic                 busy,
    output logic                 cfg_err
);

    localparam int unsigned STEP_W = 3;
    localparam int unsigned GATE_W = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [STEP_W-1:0]    step_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] blank_q, blank_d;
    logic                 strobe_d, rev_d;
    logic [GATE_W-1:0]    gates_d;
    logic                 busy_d, cfg_err_d;
    logic [STEP_W-1:0]    adv_step;
    logic                 adv_wrap;

    // Electrical order of the active vectors; anything else is the zero vector.
    function automatic logic [GATE_W-1:0] step_map(input logic [STEP_W-1:0] s);
        case (s)
            3'd0:    step_map = 6'b000001;
            3'd1:    step_map = 6'b100000;
            3'd2:    step_map = 6'b000010;
            3'd3:    step_map = 6'b001000;
            3'd4:    step_map = 6'b000100;
            3'd5:    step_map = 6'b010000;
            default: step_map = 6'b000000;
        endcase
    endfunction

    // Direction is sampled at the boundary edge, so a dir change takes effect there.
    always_comb begin
        if (dir) begin
            adv_step = (step == 3'd0) ? 3'd5 : STEP_W'(step - 3'd1);
            adv_wrap = (step == 3'd0);
        end else begin
            adv_step = (step == 3'd5) ? 3'd0 : STEP_W'(step + 3'd1);
            adv_wrap = (step == 3'd5);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step        <= '0;
            cnt_q       <= '0;
            blank_q     <= '0;
            gates       <= '0;
            step_strobe <= 1'b0;
            rev_done    <= 1'b0;
            busy        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            step        <= step_d;
            cnt_q       <= cnt_d;
            blank_q     <= blank_d;
            gates       <= gates_d;
            step_strobe <= strobe_d;
            rev_done    <= rev_d;
            busy        <= busy_d;
            cfg_err     <= cfg_err_d;
        end
    end

    // Next-state logic; every ACTIVE entry relatches config and reloads the dwell count.
    always_comb begin
        state_d  = state_q;
        step_d   = step;
        cnt_d    = cnt_q;
        blank_d  = blank_q;
        strobe_d = 1'b0;
        rev_d    = 1'b0;
        case (state_q)
            IDLE: begin
                step_d = '0;
                cnt_d  = '0;
                if (enable && (dwell != '0)) begin
                    state_d  = ACTIVE;
                    cnt_d    = CNT_WIDTH'(dwell - CNT_WIDTH'(1));
                    blank_d  = blank;
                    strobe_d = 1'b1;
                end
            end
            ACTIVE, BLANK: begin
                if (!enable) begin
                    state_d = IDLE;
                    step_d  = '0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = CNT_WIDTH'(cnt_q - CNT_WIDTH'(1));
                end else if ((state_q == ACTIVE) && (blank_q != '0)) begin
                    state_d = BLANK;
                    cnt_d   = CNT_WIDTH'(blank_q - CNT_WIDTH'(1));
                end else if (dwell == '0) begin
                    state_d = IDLE;
                    step_d  = '0;
                    cnt_d   = '0;
                end else begin
                    state_d  = ACTIVE;
                    step_d   = adv_step;
                    cnt_d    = CNT_WIDTH'(dwell - CNT_WIDTH'(1));
                    blank_d  = blank;
                    strobe_d = 1'b1;
                    rev_d    = adv_wrap;
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so the gate vector lands with the state.
    always_comb begin
        gates_d   = (state_d == ACTIVE) ? step_map(step_d) : '0;
        busy_d    = (state_d != IDLE);
        cfg_err_d = enable && (dwell == '0);
    end

endmodule
